// File: rtl/fmul_pkg.sv
// fmul_pkg: shared types and constants for the sequential FP multiplier controller.
//   - state_t       : controller states
//   - NAN..ZER      : bit positions in the 5-bit per-operand status
//   - OP_*          : bit positions in the 4-bit operation status
//   - FL_*          : bit positions in the 4-bit {invalid, overflow, underflow, inexact} flags
//   - exp_width / mant_width / bias : format helpers
package fmul_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLASS = 3'd1,
    MUL   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int ST_W = 5;
  localparam int NAN  = 4;
  localparam int INF  = 3;
  localparam int DEN  = 2;
  localparam int NRM  = 1;
  localparam int ZER  = 0;

  localparam int OP_NAN  = 3;
  localparam int OP_INF  = 2;
  localparam int OP_ZERO = 1;
  localparam int OP_INV  = 0;

  localparam int FL_INV = 3;
  localparam int FL_OVF = 2;
  localparam int FL_UNF = 1;
  localparam int FL_INX = 0;

  function automatic int exp_width(input int is_double);
    return (is_double != 0) ? 11 : 8;
  endfunction

  function automatic int mant_width(input int is_double);
    return (is_double != 0) ? 52 : 23;
  endfunction

  function automatic int bias(input int ew);
    return (2 ** (ew - 1)) - 1;
  endfunction

endpackage

// File: rtl/fmul_seq_ctrl_classify.sv
// fp_classify: combinational classification of one IEEE-754 magnitude (sign excluded).
//   i_mag    : {exponent, mantissa}
//   o_status : one-hot {nan, inf, denormal, normal, zero}
module fp_classify
  import fmul_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23
) (
  input  logic [EXP_WIDTH+MANT_WIDTH-1:0] i_mag,
  output logic [ST_W-1:0]                 o_status
);

  logic [EXP_WIDTH-1:0]  w_exp;
  logic [MANT_WIDTH-1:0] w_mant;
  logic                  w_exp_ones;
  logic                  w_exp_zero;
  logic                  w_mant_zero;

  assign w_exp       = i_mag[EXP_WIDTH+MANT_WIDTH-1 -: EXP_WIDTH];
  assign w_mant      = i_mag[MANT_WIDTH-1:0];
  assign w_exp_ones  = &w_exp;
  assign w_exp_zero  = ~|w_exp;
  assign w_mant_zero = ~|w_mant;

  always_comb begin
    o_status      = '0;
    o_status[NAN] = w_exp_ones & ~w_mant_zero;
    o_status[INF] = w_exp_ones & w_mant_zero;
    o_status[DEN] = w_exp_zero & ~w_mant_zero;
    o_status[ZER] = w_exp_zero & w_mant_zero;
    o_status[NRM] = ~w_exp_ones & ~w_exp_zero;
  end

endmodule

// File: rtl/fmul_seq_ctrl.sv
// fmul_seq_ctrl: sequencing controller for an IEEE-754 multiplier.
//   Operands arrive over in_valid/in_ready, are classified, and either take a
//   short special-case path or an iterative shift-add mantissa loop followed by
//   normalise and round-to-nearest-even. Result returns over out_valid/out_ready.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : operand handshake (in_ready only in IDLE)
//   op1, op2            : operands
//   out_valid, out_ready: result handshake (result held until taken)
//   result, flags       : product and {invalid, overflow, underflow, inexact}
// Optional feature macro FMUL_STICKY_FLAGS_EN adds flags_clr / sticky_flags,
// an accumulated flag register updated on each output handshake.
//
// state | meaning
// IDLE  | waiting for an operand pair
// CLASS | classify operands; special results resolved here
// MUL   | one multiplier bit per cycle, LSB first
// NORM  | normalise, round, range check
// DONE  | result presented until out_ready
module fmul_seq_ctrl
  import fmul_pkg::*;
#(
  parameter int IS_DOUBLE   = 0,
  parameter int EXP_WIDTH   = exp_width(IS_DOUBLE),
  parameter int MANT_WIDTH  = mant_width(IS_DOUBLE),
  parameter int TOTAL_WIDTH = EXP_WIDTH + MANT_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TOTAL_WIDTH-1:0] op1,
  input  logic [TOTAL_WIDTH-1:0] op2,
`ifdef FMUL_STICKY_FLAGS_EN
  input  logic                   flags_clr,
  output logic [3:0]             sticky_flags,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TOTAL_WIDTH-1:0] result,
  output logic [3:0]             flags
);

  localparam int PW      = 2 * (MANT_WIDTH + 1);
  localparam int SW      = EXP_WIDTH + 2;
  localparam int BIAS    = bias(EXP_WIDTH);
  localparam int EXP_MAX = (2 ** EXP_WIDTH) - 1;
  localparam logic [TOTAL_WIDTH-1:0] QUIET = TOTAL_WIDTH'(1) << (MANT_WIDTH - 1);

  state_t                   r_state, w_next;
  logic [TOTAL_WIDTH-1:0]   r_op1, r_op2, r_result;
  logic [3:0]               r_flags;
  logic [PW-1:0]            r_mcand, r_prod;
  logic [MANT_WIDTH:0]      r_mplr, r_cnt;

  logic                     w_s1, w_s2, w_sgn;
  logic [EXP_WIDTH-1:0]     w_e1, w_e2;
  logic [ST_W-1:0]          w_st1, w_st2;
  logic [3:0]               w_op_stat;
  logic                     w_z1, w_z2, w_special;
  logic [TOTAL_WIDTH-1:0]   w_spec_result, w_norm_result;
  logic [3:0]               w_spec_flags, w_norm_flags;

  logic                     w_hi, w_guard, w_sticky, w_rup;
  logic [MANT_WIDTH-1:0]    w_mant;
  logic [MANT_WIDTH:0]      w_mant_r;
  logic signed [SW-1:0]     w_exp_sum, w_exp_fin;

  assign w_s1  = r_op1[TOTAL_WIDTH-1];
  assign w_s2  = r_op2[TOTAL_WIDTH-1];
  assign w_e1  = r_op1[TOTAL_WIDTH-2 -: EXP_WIDTH];
  assign w_e2  = r_op2[TOTAL_WIDTH-2 -: EXP_WIDTH];
  assign w_sgn = w_s1 ^ w_s2;

  fp_classify #(.EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH)) u_class1 (
    .i_mag    (r_op1[TOTAL_WIDTH-2:0]),
    .o_status (w_st1)
  );

  fp_classify #(.EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH)) u_class2 (
    .i_mag    (r_op2[TOTAL_WIDTH-2:0]),
    .o_status (w_st2)
  );

  // Denormals behave as zeros of their own sign.
  assign w_z1      = w_st1[ZER] | w_st1[DEN];
  assign w_z2      = w_st2[ZER] | w_st2[DEN];
  assign w_special = ~(w_st1[NRM] & w_st2[NRM]);

  always_comb begin
    w_op_stat          = '0;
    w_op_stat[OP_NAN]  = w_st1[NAN] | w_st2[NAN];
    w_op_stat[OP_INF]  = w_st1[INF] | w_st2[INF];
    w_op_stat[OP_ZERO] = w_z1 | w_z2;
    w_op_stat[OP_INV]  = ~w_op_stat[OP_NAN] & ((w_st1[INF] & w_z2) | (w_st2[INF] & w_z1));
  end

  always_comb begin
    w_spec_flags = '0;
    if (w_op_stat[OP_NAN]) begin
      w_spec_result = w_st1[NAN] ? (r_op1 | QUIET) : (r_op2 | QUIET);
    end else if (w_op_stat[OP_INV]) begin
      w_spec_result        = {1'b1, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
      w_spec_flags[FL_INV] = 1'b1;
    end else if (w_op_stat[OP_ZERO]) begin
      w_spec_result = {w_sgn, {(TOTAL_WIDTH-1){1'b0}}};
    end else begin
      w_spec_result = {w_sgn, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    end
  end

  // Product is in [1,4): the top bit selects which window holds the mantissa.
  assign w_hi = r_prod[PW-1];

  always_comb begin
    if (w_hi) begin
      w_mant   = r_prod[PW-2 -: MANT_WIDTH];
      w_guard  = r_prod[PW-2-MANT_WIDTH];
      w_sticky = |r_prod[PW-3-MANT_WIDTH:0];
    end else begin
      w_mant   = r_prod[PW-3 -: MANT_WIDTH];
      w_guard  = r_prod[PW-3-MANT_WIDTH];
      w_sticky = |r_prod[PW-4-MANT_WIDTH:0];
    end
  end

  assign w_rup     = w_guard & (w_sticky | w_mant[0]);
  assign w_mant_r  = {1'b0, w_mant} + (MANT_WIDTH+1)'(w_rup);
  assign w_exp_sum = $signed(SW'(w_e1)) + $signed(SW'(w_e2)) - $signed(SW'(BIAS)) + $signed(SW'(w_hi));
  // A rounding carry leaves the mantissa at zero and bumps the exponent.
  assign w_exp_fin = w_exp_sum + $signed(SW'(w_mant_r[MANT_WIDTH]));

  always_comb begin
    w_norm_flags = '0;
    if (w_exp_fin >= $signed(SW'(EXP_MAX))) begin
      w_norm_result        = {w_sgn, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
      w_norm_flags[FL_OVF] = 1'b1;
      w_norm_flags[FL_INX] = 1'b1;
    end else if (w_exp_fin <= $signed(SW'(0))) begin
      w_norm_result        = {w_sgn, {(TOTAL_WIDTH-1){1'b0}}};
      w_norm_flags[FL_UNF] = 1'b1;
      w_norm_flags[FL_INX] = 1'b1;
    end else begin
      w_norm_result        = {w_sgn, w_exp_fin[EXP_WIDTH-1:0], w_mant_r[MANT_WIDTH-1:0]};
      w_norm_flags[FL_INX] = w_guard | w_sticky;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = CLASS;
      CLASS:   w_next = w_special ? DONE : MUL;
      MUL:     if (r_cnt == '0) w_next = NORM;
      NORM:    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op1    <= '0;
      r_op2    <= '0;
      r_mcand  <= '0;
      r_mplr   <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op1 <= op1;
            r_op2 <= op2;
          end
        end
        CLASS: begin
          r_mcand <= PW'({1'b1, r_op1[MANT_WIDTH-1:0]});
          r_mplr  <= {1'b1, r_op2[MANT_WIDTH-1:0]};
          r_prod  <= '0;
          r_cnt   <= (MANT_WIDTH+1)'(MANT_WIDTH);
          if (w_special) begin
            r_result <= w_spec_result;
            r_flags  <= w_spec_flags;
          end
        end
        MUL: begin
          if (r_mplr[0]) r_prod <= r_prod + r_mcand;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          r_cnt   <= r_cnt - 1'b1;
        end
        NORM: begin
          r_result <= w_norm_result;
          r_flags  <= w_norm_flags;
        end
        default: ;
      endcase
    end
  end

`ifdef FMUL_STICKY_FLAGS_EN
  logic [3:0] r_sticky;

  // Clear takes priority over a same-cycle handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       r_sticky <= '0;
    else if (flags_clr)                            r_sticky <= '0;
    else if ((r_state == DONE) && out_ready)       r_sticky <= r_sticky | r_flags;
  end

  assign sticky_flags = r_sticky;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign flags     = r_flags;

endmodule
